// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles little-endian words, writes them to memory,
// checks a trailing XOR checksum and releases the CPU from reset on success.
module prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam int unsigned MaxWords = (1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e      state;
    logic [7:0]  cnt_lo;
    logic [7:0]  csum;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    logic        hs;
    logic [15:0] hdr_n;
    logic [31:0] addr_full;

    assign hs        = in_valid && in_ready;
    assign hdr_n     = {in_data, cnt_lo};
    assign addr_full = BASE_ADDR + {16'd0, word_idx};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= StHdr0;
            cnt_lo    <= 8'd0;
            csum      <= 8'd0;
            n_words   <= 16'd0;
            word_idx  <= 16'd0;
            byte_cnt  <= 2'd0;
            shift     <= 24'd0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_rstn  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                StHdr0: begin
                    if (hs) begin
                        cnt_lo <= in_data;
                        csum   <= csum ^ in_data;
                        busy   <= 1'b1;
                        state  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (hs) begin
                        csum    <= csum ^ in_data;
                        n_words <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state <= StCsum;
                        end else if ({16'd0, hdr_n} > MaxWords) begin
                            state    <= StErr;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (hs) begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {in_data, shift[23:8]};
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_full[ADDR_W-1:0];
                            mem_wdata <= {in_data, shift};
                            word_idx  <= word_idx + 16'd1;
                            if (word_idx == n_words - 16'd1) begin
                                state <= StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (hs) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state     <= StRun;
                            cpu_rstn  <= 1'b1;
                            load_done <= 1'b1;
                        end else begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end
                    end
                end
                StRun, StErr: begin
                    if (load_req) begin
                        state     <= StHdr0;
                        in_ready  <= 1'b1;
                        cpu_rstn  <= 1'b0;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        csum      <= 8'd0;
                        word_idx  <= 16'd0;
                        byte_cnt  <= 2'd0;
                    end
                end
                default: state <= StHdr0;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized frames against a frame-level model.
module tb_prog_loader;

    localparam int unsigned BASE = 0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, load_req;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_rstn, load_done, load_err, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        in_valid4, load_req4;
    logic [7:0]  in_data4;
    logic        in_ready4, mem_we4, cpu_rstn4, load_done4, load_err4, busy4;
    logic [3:0]  mem_addr4;
    logic [31:0] mem_wdata4;

    int n_checks = 0;
    int n_errors = 0;
    int we4_cnt  = 0;

    logic [31:0] exp_words[$];
    logic [7:0]  frame_bytes[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rstn(cpu_rstn), .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .load_req(load_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .cpu_rstn(cpu_rstn4), .load_done(load_done4), .load_err(load_err4), .busy(busy4)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back({22'd0, mem_addr});
            wr_data.push_back(mem_wdata);
        end
        if (mem_we4 === 1'b1) we4_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Frame model: header, words little-endian, XOR of everything before the checksum.
    function automatic void build_frame(input logic [7:0] corrupt);
        logic [7:0]  cs;
        logic [15:0] n;
        frame_bytes.delete();
        n = 16'(exp_words.size());
        frame_bytes.push_back(n[7:0]);
        frame_bytes.push_back(n[15:8]);
        foreach (exp_words[i])
            for (int k = 0; k < 4; k++) frame_bytes.push_back(exp_words[i][8*k +: 8]);
        cs = 8'd0;
        foreach (frame_bytes[i]) cs ^= frame_bytes[i];
        frame_bytes.push_back(cs ^ corrupt);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        tries    = 0;
        while (in_ready !== 1'b1 && tries < 50) begin
            @(posedge clk);
            #1;
            tries++;
        end
        if (in_ready !== 1'b1) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] corrupt, input int gmin,
                             input int gmax);
        build_frame(corrupt);
        wr_addr.delete();
        wr_data.delete();
        foreach (frame_bytes[i]) begin
            send_byte(frame_bytes[i], (gmax == 0) ? 0 : int'($urandom_range(gmax, gmin)));
            if (i == 0) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk({tag, "_nwrites"}, wr_addr.size(), exp_words.size());
        foreach (exp_words[i]) begin
            if (i < wr_addr.size()) begin
                chk({tag, "_addr"}, wr_addr[i], BASE + i);
                chk({tag, "_data"}, wr_data[i], exp_words[i]);
            end
        end
        chk({tag, "_done"}, {31'd0, load_done}, (corrupt == 0) ? 32'd1 : 32'd0);
        chk({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, (corrupt == 0) ? 32'd1 : 32'd0);
        chk({tag, "_err"}, {31'd0, load_err}, (corrupt == 0) ? 32'd0 : 32'd1);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        #1;
    endtask

    task automatic restart(input string tag);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        chk({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, 32'd0);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, 32'd0);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        load_req  = 1'b0;
        in_valid4 = 1'b0;
        in_data4  = 8'd0;
        load_req4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rstn = 1'b1;

        // ADDR_W=4: 17 words exceed the 16-word space.
        in_valid4 = 1'b1;
        in_data4  = 8'd17;
        @(posedge clk);
        #1;
        in_data4 = 8'd0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        chk("range_err", {31'd0, load_err4}, 32'd1);
        chk("range_in_ready", {31'd0, in_ready4}, 32'd0);
        chk("range_cpu_rstn", {31'd0, cpu_rstn4}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("range_no_we", we4_cnt, 32'd0);

        exp_words = '{32'h11223344, 32'hDEADBEEF};
        run_frame("fixed", 8'h00, 0, 0);
        restart("restart_run");
        run_frame("badcs", 8'h01, 0, 0);
        restart("restart_err");

        // load_req while idle in HDR0 must be ignored.
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        chk("idle_req_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_req_busy", {31'd0, busy}, 32'd0);

        exp_words.delete();
        run_frame("n0", 8'h00, 0, 0);
        restart("restart_n0");

        exp_words = '{$urandom()};
        run_frame("gaps", 8'h00, 1, 5);
        restart("restart_gaps");

        for (int it = 0; it < 4; it++) begin
            exp_words.delete();
            for (int w = 0; w < int'($urandom_range(8, 1)); w++) exp_words.push_back($urandom());
            run_frame("rand", 8'h00, 0, 3);
            restart("restart_rand");
        end

        // Asynchronous reset six bytes into an N=2 frame.
        exp_words = '{$urandom(), $urandom()};
        build_frame(8'h00);
        for (int i = 0; i < 6; i++) send_byte(frame_bytes[i], 0);
        rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_words = '{$urandom(), $urandom()};
        run_frame("after_reset", 8'h00, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
